// File: rtl/sincos_request_arbiter_if.sv
// Request/response and shared-datapath bus between the decoder array and the sin/cos arbiter.
interface sincos_request_arbiter_if #(
    parameter int unsigned NUM_REQ          = 4,
    parameter int unsigned DATA_WIDTH       = 32,
    parameter int unsigned CODE_WIDTH       = 8,
    parameter int unsigned ANGLE_ADDR_WIDTH = 5
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*CODE_WIDTH-1:0] req_code;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ-1:0]            resp_valid;
    logic [DATA_WIDTH-1:0]         resp_value;
    logic                          busy;
    logic [ANGLE_ADDR_WIDTH-1:0]   mem_angle_normalized_addr;
    logic [DATA_WIDTH-1:0]         mem_angle_normalized_data_out;
    logic [DATA_WIDTH-1:0]         out_angle;
    logic                          out_sine_cosine;
    logic                          sin_calc_start;
    logic [DATA_WIDTH-1:0]         inp_sine_cosine_value;

    // Arbiter side
    modport slave (
        input  req_valid, req_code, mem_angle_normalized_data_out, inp_sine_cosine_value,
        output req_ready, resp_valid, resp_value, busy, mem_angle_normalized_addr,
               out_angle, out_sine_cosine, sin_calc_start
    );

    // Requesters plus ROM / sin-cos datapath side
    modport master (
        output req_valid, req_code, mem_angle_normalized_data_out, inp_sine_cosine_value,
        input  req_ready, resp_valid, resp_value, busy, mem_angle_normalized_addr,
               out_angle, out_sine_cosine, sin_calc_start
    );
endinterface

// File: rtl/sincos_request_arbiter.sv
// Round-robin arbiter sharing one angle ROM and one sin/cos unit among NUM_REQ decoders.
// One transaction at a time: grant -> ROM read -> sin/cos launch -> response strobe.
module sincos_request_arbiter #(
    parameter int unsigned NUM_REQ          = 4,
    parameter int unsigned DATA_WIDTH       = 32,
    parameter int unsigned CODE_WIDTH       = 8,
    parameter int unsigned ANGLE_ADDR_WIDTH = 5,
    parameter int unsigned MEM_DELAY        = 2,
    parameter int unsigned SIN_CALC_DELAY   = 3
) (
    input  logic                   clock,
    input  logic                   reset,
    sincos_request_arbiter_if.slave bus
);
    localparam int unsigned GRANT_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned MEM_CNT_W = (MEM_DELAY > 1) ? $clog2(MEM_DELAY) : 1;
    localparam int unsigned SIN_CNT_W = (SIN_CALC_DELAY > 1) ? $clog2(SIN_CALC_DELAY) : 1;
    localparam int unsigned FUNC_BIT  = CODE_WIDTH - 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MEM_WAIT,
        S_SIN_START,
        S_SIN_WAIT,
        S_RESPOND
    } state_e;

    state_e                      state_q,        state_d;
    logic [GRANT_W-1:0]          last_grant_q,   last_grant_d;
    logic [ANGLE_ADDR_WIDTH-1:0] addr_q,         addr_d;
    logic                        func_q,         func_d;
    logic [MEM_CNT_W-1:0]        mem_cnt_q,      mem_cnt_d;
    logic [SIN_CNT_W-1:0]        sin_cnt_q,      sin_cnt_d;
    logic [NUM_REQ-1:0]          req_ready_q,    req_ready_d;
    logic [NUM_REQ-1:0]          resp_valid_q,   resp_valid_d;
    logic [DATA_WIDTH-1:0]       resp_value_q,   resp_value_d;
    logic                        busy_q,         busy_d;
    logic [DATA_WIDTH-1:0]       out_angle_q,    out_angle_d;
    logic                        out_sc_q,       out_sc_d;
    logic                        sin_start_q,    sin_start_d;

    logic                        found_c;
    logic [GRANT_W-1:0]          pick_c;
    logic [ANGLE_ADDR_WIDTH-1:0] pick_addr_c;
    logic                        pick_func_c;

    // Requester index at a given offset past the last grant, wrapping at NUM_REQ
    function automatic int unsigned rr_idx(logic [GRANT_W-1:0] last, int unsigned off);
        return (32'(last) + off) % NUM_REQ;
    endfunction

    // Round-robin pick: first valid requester after the last grant; only the address
    // bits and the function-select bit of the code are ever needed downstream
    always_comb begin
        found_c     = 1'b0;
        pick_c      = last_grant_q;
        pick_addr_c = '0;
        pick_func_c = 1'b0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            if (!found_c && bus.req_valid[rr_idx(last_grant_q, k)]) begin
                found_c     = 1'b1;
                pick_c      = GRANT_W'(rr_idx(last_grant_q, k));
                pick_addr_c = bus.req_code[rr_idx(last_grant_q, k)*CODE_WIDTH +: ANGLE_ADDR_WIDTH];
                pick_func_c = bus.req_code[rr_idx(last_grant_q, k)*CODE_WIDTH + FUNC_BIT];
            end
        end
    end

    // Next-state and next-output logic; strobes default low so they last one cycle
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        func_d       = func_q;
        mem_cnt_d    = mem_cnt_q;
        sin_cnt_d    = sin_cnt_q;
        req_ready_d  = '0;
        resp_valid_d = '0;
        resp_value_d = resp_value_q;
        out_angle_d  = out_angle_q;
        out_sc_d     = out_sc_q;
        sin_start_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (found_c) begin
                    last_grant_d = pick_c;
                    addr_d       = pick_addr_c;
                    func_d       = pick_func_c;
                    req_ready_d  = NUM_REQ'(1) << pick_c;
                    state_d      = S_MEM_WAIT;
                end
            end
            S_MEM_WAIT: begin
                if (mem_cnt_q == '0) begin
                    mem_cnt_d = MEM_CNT_W'(MEM_DELAY - 1);
                    state_d   = S_SIN_START;
                end else begin
                    mem_cnt_d = mem_cnt_q - MEM_CNT_W'(1);
                end
            end
            S_SIN_START: begin
                out_angle_d = bus.mem_angle_normalized_data_out;
                out_sc_d    = func_q;
                sin_start_d = 1'b1;
                state_d     = S_SIN_WAIT;
            end
            S_SIN_WAIT: begin
                if (sin_cnt_q == '0) begin
                    sin_cnt_d = SIN_CNT_W'(SIN_CALC_DELAY - 1);
                    state_d   = S_RESPOND;
                end else begin
                    sin_cnt_d = sin_cnt_q - SIN_CNT_W'(1);
                end
            end
            S_RESPOND: begin
                resp_value_d = bus.inp_sine_cosine_value;
                resp_valid_d = NUM_REQ'(1) << last_grant_q;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers; reset aborts any transaction in flight
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            last_grant_q <= GRANT_W'(NUM_REQ - 1);
            addr_q       <= '0;
            func_q       <= 1'b0;
            mem_cnt_q    <= MEM_CNT_W'(MEM_DELAY - 1);
            sin_cnt_q    <= SIN_CNT_W'(SIN_CALC_DELAY - 1);
            req_ready_q  <= '0;
            resp_valid_q <= '0;
            resp_value_q <= '0;
            busy_q       <= 1'b0;
            out_angle_q  <= '0;
            out_sc_q     <= 1'b0;
            sin_start_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            func_q       <= func_d;
            mem_cnt_q    <= mem_cnt_d;
            sin_cnt_q    <= sin_cnt_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_value_q <= resp_value_d;
            busy_q       <= busy_d;
            out_angle_q  <= out_angle_d;
            out_sc_q     <= out_sc_d;
            sin_start_q  <= sin_start_d;
        end
    end

    assign bus.req_ready                 = req_ready_q;
    assign bus.resp_valid                = resp_valid_q;
    assign bus.resp_value                = resp_value_q;
    assign bus.busy                      = busy_q;
    assign bus.mem_angle_normalized_addr = addr_q;
    assign bus.out_angle                 = out_angle_q;
    assign bus.out_sine_cosine           = out_sc_q;
    assign bus.sin_calc_start            = sin_start_q;
endmodule

// File: tb/tb_sincos_request_arbiter.sv
// Bench for sincos_request_arbiter: two instances (2/3 and 1/5 delays), ROM and sin/cos
// models, a round-robin reference model feeding an expected-response queue per instance.
module tb_sincos_request_arbiter;
    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned DW      = 32;
    localparam int unsigned CW      = 8;
    localparam int unsigned AW      = 5;
    localparam int unsigned MD_A = 2, SD_A = 3, MD_B = 1, SD_B = 5;

    typedef struct {
        int unsigned   req;
        logic [AW-1:0] addr;
        logic          func;
        logic [DW-1:0] val;
        int unsigned   due;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors     = 0;
    int miscompares = 0;

    logic                   reset   [2];
    logic [NUM_REQ-1:0]     rv      [2];
    logic [NUM_REQ*CW-1:0]  rc      [2];
    logic [NUM_REQ-1:0]     rdy_obs [2];
    logic [NUM_REQ-1:0]     rsp_obs [2];
    logic                   busy_obs[2];
    logic                   start_obs[2];
    logic                   sc_obs  [2];
    logic [DW-1:0]          val_obs [2];
    logic [DW-1:0]          angle_obs[2];
    logic [AW-1:0]          addr_obs[2];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Angle ROM contents
    function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
        return (DW'(a) * 32'h0102_0409) ^ 32'h5A00_00C3;
    endfunction

    // Stand-in for the sin/cos unit transfer function
    function automatic logic [DW-1:0] sincos_model(input logic [DW-1:0] angle, input logic func);
        return func ? ((angle >> 1) ^ 32'hFFFF_0000) : (angle + 32'h0001_1111);
    endfunction

    function automatic int unsigned rr_pick(input int unsigned last, input logic [NUM_REQ-1:0] v);
        for (int unsigned n = 1; n <= NUM_REQ; n++)
            if (v[(last + n) % NUM_REQ]) return (last + n) % NUM_REQ;
        return 0;
    endfunction

    function automatic exp_t make_exp(input int unsigned g, input logic [NUM_REQ*CW-1:0] codes,
                                      input int unsigned due);
        exp_t e;
        logic [CW-1:0] c;
        c      = codes[g*CW +: CW];
        e.req  = g;
        e.addr = c[AW-1:0];
        e.func = c[CW-3];
        e.val  = sincos_model(rom_word(c[AW-1:0]), c[CW-3]);
        e.due  = due;
        return e;
    endfunction

    function automatic logic [CW-1:0] code_for(input int unsigned i, input int unsigned n);
        return CW'(i * 53 + n * 29 + 7);
    endfunction

    for (genvar k = 0; k < 2; k++) begin : g_inst
        localparam int unsigned MD  = (k == 0) ? MD_A : MD_B;
        localparam int unsigned SD  = (k == 0) ? SD_A : SD_B;
        localparam int unsigned LAT = MD + SD + 3;

        sincos_request_arbiter_if #(
            .NUM_REQ(NUM_REQ), .DATA_WIDTH(DW), .CODE_WIDTH(CW), .ANGLE_ADDR_WIDTH(AW)
        ) bus ();

        sincos_request_arbiter #(
            .NUM_REQ(NUM_REQ), .DATA_WIDTH(DW), .CODE_WIDTH(CW), .ANGLE_ADDR_WIDTH(AW),
            .MEM_DELAY(MD), .SIN_CALC_DELAY(SD)
        ) u_dut (
            .clock(clk),
            .reset(reset[k]),
            .bus  (bus)
        );

        logic [DW-1:0] rom_pipe [MD];
        logic [DW-1:0] sc_pipe  [SD];

        assign bus.req_valid = rv[k];
        assign bus.req_code  = rc[k];

        // ROM with MD cycles of read latency
        always @(posedge clk) begin
            rom_pipe[0] <= rom_word(bus.mem_angle_normalized_addr);
            for (int i = 1; i < int'(MD); i++) rom_pipe[i] <= rom_pipe[i-1];
        end
        assign bus.mem_angle_normalized_data_out = rom_pipe[MD-1];

        // Sin/cos unit: result valid exactly SD cycles after start, junk otherwise
        always @(posedge clk) begin
            sc_pipe[0] <= bus.sin_calc_start ? sincos_model(bus.out_angle, bus.out_sine_cosine)
                                             : (32'hBAD0_0000 | DW'(cyc));
            for (int i = 1; i < int'(SD); i++) sc_pipe[i] <= sc_pipe[i-1];
        end
        assign bus.inp_sine_cosine_value = sc_pipe[SD-1];

        assign rdy_obs[k]   = bus.req_ready;
        assign rsp_obs[k]   = bus.resp_valid;
        assign busy_obs[k]  = bus.busy;
        assign start_obs[k] = bus.sin_calc_start;
        assign sc_obs[k]    = bus.out_sine_cosine;
        assign val_obs[k]   = bus.resp_value;
        assign angle_obs[k] = bus.out_angle;
        assign addr_obs[k]  = bus.mem_angle_normalized_addr;

        exp_t               q[$];
        logic [NUM_REQ-1:0] exp_rdy    = '0;
        int unsigned        mlg        = NUM_REQ - 1;
        logic               prev_start = 1'b0;

        // Reference arbiter: predicts the grant and queues the expected response
        always @(posedge clk) begin
            if (reset[k]) begin
                mlg     <= NUM_REQ - 1;
                exp_rdy <= '0;
                q.delete();
            end else if (busy_obs[k] === 1'b0 && rv[k] != '0) begin
                exp_rdy <= NUM_REQ'(1) << rr_pick(mlg, rv[k]);
                mlg     <= rr_pick(mlg, rv[k]);
                q.push_back(make_exp(rr_pick(mlg, rv[k]), rc[k], cyc + LAT));
            end else begin
                exp_rdy <= '0;
            end
        end

        // Output checker, sampled mid-cycle
        always @(negedge clk) begin
            if (bus.req_ready != '0 || exp_rdy != '0)
                check_eq($sformatf("req_ready[%0d]", k), 64'(bus.req_ready), 64'(exp_rdy));
            if (bus.sin_calc_start === 1'b1) begin
                check_eq($sformatf("start_pulse[%0d]", k), 64'(prev_start), 64'(0));
                if (q.size() == 0) begin
                    check_eq($sformatf("start_no_txn[%0d]", k), 64'(bus.sin_calc_start), 64'(0));
                end else begin
                    check_eq($sformatf("rom_angle[%0d]", k), 64'(bus.out_angle), 64'(rom_word(q[0].addr)));
                    check_eq($sformatf("func_sel[%0d]", k), 64'(bus.out_sine_cosine), 64'(q[0].func));
                end
            end
            prev_start <= bus.sin_calc_start;
            if (bus.resp_valid != '0) begin
                if (q.size() == 0) begin
                    check_eq($sformatf("resp_unexpected[%0d]", k), 64'(bus.resp_valid), 64'(0));
                end else begin
                    check_eq($sformatf("resp_who[%0d]", k), 64'(bus.resp_valid), 64'(NUM_REQ'(1) << q[0].req));
                    check_eq($sformatf("resp_value[%0d]", k), 64'(bus.resp_value), 64'(q[0].val));
                    check_eq($sformatf("resp_cycle[%0d]", k), 64'(cyc), 64'(q[0].due));
                    void'(q.pop_front());
                end
            end else if (q.size() != 0 && cyc > q[0].due) begin
                check_eq($sformatf("resp_timeout[%0d]", k), 64'(bus.resp_valid), 64'(NUM_REQ'(1) << q[0].req));
                void'(q.pop_front());
            end
        end
    end

    task automatic check_idle(input int k, input string tag);
        check_eq({tag, "_busy"},  64'(busy_obs[k]),  64'(0));
        check_eq({tag, "_ready"}, 64'(rdy_obs[k]),   64'(0));
        check_eq({tag, "_resp"},  64'(rsp_obs[k]),   64'(0));
        check_eq({tag, "_value"}, 64'(val_obs[k]),   64'(0));
        check_eq({tag, "_addr"},  64'(addr_obs[k]),  64'(0));
        check_eq({tag, "_angle"}, 64'(angle_obs[k]), 64'(0));
        check_eq({tag, "_func"},  64'(sc_obs[k]),    64'(0));
        check_eq({tag, "_start"}, 64'(start_obs[k]), 64'(0));
    endtask

    task automatic issue(input int k, input int i, input logic [CW-1:0] code);
        rv[k][i]           = 1'b1;
        rc[k][i*CW +: CW]  = code;
    endtask

    task automatic wait_ready(input int k, input int i, output int unsigned c);
        for (int n = 0; n < 64; n++) begin
            @(negedge clk);
            if (rdy_obs[k][i] === 1'b1) begin c = cyc; return; end
        end
        check_eq("ready_wait", 64'(rdy_obs[k][i]), 64'(1));
        c = cyc;
    endtask

    task automatic wait_start(input int k, output int unsigned c);
        for (int n = 0; n < 64; n++) begin
            @(negedge clk);
            if (start_obs[k] === 1'b1) begin c = cyc; return; end
        end
        check_eq("start_wait", 64'(start_obs[k]), 64'(1));
        c = cyc;
    endtask

    task automatic wait_resp(input int k, input int i, output int unsigned c);
        for (int n = 0; n < 64; n++) begin
            @(negedge clk);
            if (rsp_obs[k][i] === 1'b1) begin c = cyc; return; end
        end
        check_eq("resp_wait", 64'(rsp_obs[k][i]), 64'(1));
        c = cyc;
    endtask

    // Serve four grants on instance k; seq holds the expected grant order, 2 bits per entry
    task automatic serve(input int k, input logic [NUM_REQ-1:0] keep, input logic [7:0] seq);
        int got  = 0;
        int idle = 0;
        while (got < 4 && idle < 100) begin
            @(negedge clk);
            idle++;
            for (int i = 0; i < int'(NUM_REQ); i++) begin
                if (rdy_obs[k][i] === 1'b1 && got < 4) begin
                    check_eq("rr_order", 64'(i), 64'(seq[2*got +: 2]));
                    got++;
                    idle = 0;
                    if (keep[i]) rc[k][i*CW +: CW] = code_for(i, got);
                    else         rv[k][i] = 1'b0;
                end
            end
        end
        if (got < 4) check_eq("serve_grants", 64'(got), 64'(4));
        rv[k] = '0;
    endtask

    task automatic drain();
        repeat (14) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed running, expected finished");
        $fatal(1);
    end

    initial begin
        int unsigned t0, c1, c2, c3;
        for (int k = 0; k < 2; k++) begin
            reset[k] = 1'b1;
            rv[k]    = '0;
            rc[k]    = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle(0, "rst_a");
        check_idle(1, "rst_b");
        reset[0] = 1'b0;
        reset[1] = 1'b0;

        // Single request: requester 2, code 0x25
        @(posedge clk); #1;
        t0 = cyc;
        issue(0, 2, 8'h25);
        wait_ready(0, 2, c1);
        rv[0][2] = 1'b0;
        check_eq("t1_ready_lat", 64'(c1 - t0), 64'(1));
        check_eq("t1_addr", 64'(addr_obs[0]), 64'(5'h05));
        wait_start(0, c2);
        check_eq("t1_start_lat", 64'(c2 - t0), 64'(4));
        check_eq("t1_func", 64'(sc_obs[0]), 64'(1));
        wait_resp(0, 2, c3);
        check_eq("t1_resp_lat", 64'(c3 - t0), 64'(8));
        drain();

        // All four held together after a fresh reset: grants 0,1,2,3
        reset[0] = 1'b1;
        @(negedge clk);
        reset[0] = 1'b0;
        for (int i = 0; i < int'(NUM_REQ); i++) issue(0, i, code_for(i, 0));
        serve(0, 4'b0000, 8'b11_10_01_00);
        drain();

        // Fairness: 0 and 3 re-request continuously, grants 0,3,0,3 after wrap
        issue(0, 0, code_for(0, 9));
        issue(0, 3, code_for(3, 9));
        serve(0, 4'b1001, 8'b11_00_11_00);
        drain();

        // Reset during SIN_WAIT aborts; then requester 1 completes normally
        issue(0, 1, 8'h4C);
        wait_ready(0, 1, c1);
        rv[0][1] = 1'b0;
        wait_start(0, c2);
        reset[0] = 1'b1;
        @(negedge clk);
        check_idle(0, "abort");
        reset[0] = 1'b0;
        drain();
        issue(0, 1, 8'h93);
        wait_ready(0, 1, c1);
        rv[0][1] = 1'b0;
        wait_resp(0, 1, c3);
        check_eq("t4_resp_lat", 64'(c3 - c1), 64'(7));
        drain();

        // Back-to-back: requester 1 re-requests in its response cycle
        issue(0, 1, 8'h2E);
        wait_ready(0, 1, c1);
        rv[0][1] = 1'b0;
        wait_resp(0, 1, c2);
        issue(0, 1, 8'hB7);
        wait_ready(0, 1, c1);
        rv[0][1] = 1'b0;
        check_eq("t5_ready_next", 64'(c1 - c2), 64'(1));
        wait_resp(0, 1, c3);
        check_eq("t5_resp_gap", 64'(c3 - c2), 64'(8));
        drain();

        // Second instance: MEM_DELAY=1, SIN_CALC_DELAY=5
        for (int n = 0; n < 2; n++) begin
            @(negedge clk);
            t0 = cyc;
            issue(1, 0, (n == 0) ? 8'h3A : 8'hC5);
            wait_ready(1, 0, c1);
            rv[1][0] = 1'b0;
            check_eq("t6_ready_lat", 64'(c1 - t0), 64'(1));
            wait_start(1, c2);
            check_eq("t6_start_lat", 64'(c2 - t0), 64'(MD_B + 2));
            wait_resp(1, 0, c3);
            check_eq("t6_resp_lat", 64'(c3 - t0), 64'(MD_B + SD_B + 3));
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
